// File: rtl/password_ctrl.sv
// Keypad password lock: collects up to four BCD digits, compares on Enter, holds the
// lock open for T_OPEN clocks and abandons a partial entry after T_TIMEOUT idle clocks.
module password_ctrl #(
  parameter logic [15:0] PASSWORD  = 16'h1234,
  parameter logic [27:0] T_TIMEOUT = 28'd120000000,
  parameter logic [27:0] T_OPEN    = 28'd60000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic        pw_false,
  output logic        timeout_flag,
  output logic        unlock,
  output logic [15:0] entry,
  output logic [2:0]  digit_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_INPUT, S_OPEN} state_t;

  state_t      state_q, state_d;
  logic [15:0] entry_q, entry_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [27:0] idle_q, idle_d;
  logic [27:0] hold_q, hold_d;
  logic        pwf_q, pwf_d;
  logic        tmo_q, tmo_d;
  logic        unl_q, unl_d;

  logic is_digit, is_clear, is_enter;

  assign is_digit = key_valid && (key_code <= 4'd9);
  assign is_clear = key_valid && (key_code == 4'd10);
  assign is_enter = key_valid && (key_code == 4'd11);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      entry_q <= '0;
      cnt_q   <= '0;
      idle_q  <= '0;
      hold_q  <= '0;
      pwf_q   <= 1'b0;
      tmo_q   <= 1'b0;
      unl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      hold_q  <= hold_d;
      pwf_q   <= pwf_d;
      tmo_q   <= tmo_d;
      unl_q   <= unl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    cnt_d   = cnt_q;
    idle_d  = '0;
    hold_d  = '0;
    pwf_d   = 1'b0;
    tmo_d   = 1'b0;
    unl_d   = unl_q;
    unique case (state_q)
      S_IDLE: begin
        unl_d = 1'b0;
        if (is_digit) begin
          entry_d = {12'h000, key_code};
          cnt_d   = 3'd1;
          state_d = S_INPUT;
        end else if (is_clear) begin
          entry_d = '0;
          cnt_d   = '0;
        end
      end
      S_INPUT: begin
        // A dropped fifth digit is not an accepted key, so it neither restarts nor blocks the timeout.
        if (is_digit && (cnt_q < 3'd4)) begin
          entry_d = {entry_q[11:0], key_code};
          cnt_d   = cnt_q + 3'd1;
        end else if (is_clear) begin
          entry_d = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (is_enter) begin
          entry_d = '0;
          cnt_d   = '0;
          if ((cnt_q == 3'd4) && (entry_q == PASSWORD)) begin
            unl_d   = 1'b1;
            state_d = S_OPEN;
          end else begin
            pwf_d   = 1'b1;
            state_d = S_IDLE;
          end
        end else if (idle_q >= T_TIMEOUT - 28'd1) begin
          tmo_d   = 1'b1;
          entry_d = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          idle_d = idle_q + 28'd1;
        end
      end
      S_OPEN: begin
        if (is_enter || (hold_q >= T_OPEN - 28'd1)) begin
          unl_d   = 1'b0;
          state_d = S_IDLE;
        end else begin
          hold_d = hold_q + 28'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        entry_d = '0;
        cnt_d   = '0;
        unl_d   = 1'b0;
      end
    endcase
  end

  assign pw_false     = pwf_q;
  assign timeout_flag = tmo_q;
  assign unlock       = unl_q;
  assign entry        = entry_q;
  assign digit_cnt    = cnt_q;

endmodule
